// File: rtl/ct_f_spsram_ctrl_pkg.sv
// Shared types and constants for the 2048x128 single-port SRAM request sequencer.
package ct_f_spsram_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_RSP_DEPTH  = 2;

  localparam logic [DEF_DATA_WIDTH-1:0] WEN_ALL0 = {DEF_DATA_WIDTH{1'b0}};
  localparam logic [DEF_DATA_WIDTH-1:0] WEN_ALL1 = {DEF_DATA_WIDTH{1'b1}};

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/ct_f_spsram_2048x128_ctrl_if.sv
// Request/response handshake bundle between a client (master) and the SRAM sequencer (slave).
interface ct_f_spsram_2048x128_ctrl_if
  import ct_f_spsram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  init_done;

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_data, init_done
  );

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, rsp_rdy,
    output req_rdy, rsp_vld, rsp_data, init_done
  );

endinterface

// File: rtl/ct_f_spsram_ctrl_rspbuf.sv
// Small in-order response FIFO; head entry is presented directly, push is refused only when truly full.
module ct_f_spsram_ctrl_rspbuf #(
  parameter int DEPTH = 2,
  parameter int DW    = 128,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [DW-1:0] mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          full_s;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty     = (count_r == {CW{1'b0}});
  assign full_s    = (count_r == CW'(DEPTH));
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full_s || do_pop_s);
  assign count     = count_r;
  assign head_data = mem_r[rd_ptr_r];

  // Pointer and occupancy tracking; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/ct_f_spsram_2048x128_ctrl.sv
// Request sequencer for the 2048x128 single-port SRAM wrapper: valid/ready requests to CEN/GWEN/WEN pins.
// Define CT_F_SPSRAM_CTRL_INIT_EN to zero-fill the whole array after reset before accepting traffic.
module ct_f_spsram_2048x128_ctrl
  import ct_f_spsram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  ct_f_spsram_2048x128_ctrl_if.slave bus,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic                  GWEN,
  output logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] Q
);

  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
  localparam logic [CNT_W:0]        DEPTH_C  = (CNT_W + 1)'(RSP_DEPTH);
  localparam logic [DATA_WIDTH-1:0] WEN_WR   = DATA_WIDTH'(WEN_ALL0);
  localparam logic [DATA_WIDTH-1:0] WEN_IDLE = ~WEN_WR;

  state_e                state_r;
  state_e                state_nxt_s;
  logic                  rd_inflight_r;
  logic [ADDR_WIDTH-1:0] a_r;
  logic [DATA_WIDTH-1:0] d_r;
  logic [CNT_W-1:0]      buf_count_s;
  logic                  buf_empty_s;
  logic                  buf_pop_s;
  logic [CNT_W:0]        credit_used_s;
  logic                  run_s;
  logic                  req_rdy_s;
  logic                  wr_hs_s;
  logic                  rd_hs_s;

`ifdef CT_F_SPSRAM_CTRL_INIT_EN
  logic [ADDR_WIDTH-1:0] init_cnt_r;
  logic                  init_active_s;
  logic                  init_last_s;

  assign init_active_s = (state_r == ST_INIT) && !RST;
  assign init_last_s   = (init_cnt_r == {ADDR_WIDTH{1'b1}});

  // Zero-fill address counter; wraps back to 0 after the last word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      init_cnt_r <= {ADDR_WIDTH{1'b0}};
    end else if (init_active_s) begin
      init_cnt_r <= init_cnt_r + 1'b1;
    end else begin
      init_cnt_r <= init_cnt_r;
    end
  end
`endif

  // Credit counts both buffered responses and the read whose Q arrives this cycle.
  assign run_s         = (state_r == ST_RUN) && !RST;
  assign credit_used_s = {1'b0, buf_count_s} + {{CNT_W{1'b0}}, rd_inflight_r};
  assign req_rdy_s     = run_s && (credit_used_s < DEPTH_C);
  assign wr_hs_s       = bus.req_vld && req_rdy_s && bus.req_wr;
  assign rd_hs_s       = bus.req_vld && req_rdy_s && !bus.req_wr;
  assign buf_pop_s     = bus.rsp_rdy && !buf_empty_s;

  assign bus.req_rdy   = req_rdy_s;
  assign bus.rsp_vld   = !buf_empty_s;
  assign bus.init_done = (state_r == ST_RUN);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; without zero-fill INIT is a single idle cycle after reset.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
`ifdef CT_F_SPSRAM_CTRL_INIT_EN
        if (init_last_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
`else
        state_nxt_s = ST_RUN;
`endif
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // SRAM pins follow the accepted request in the same cycle; A and D hold when idle.
  always_comb begin
    CEN  = 1'b1;
    GWEN = 1'b1;
    WEN  = WEN_IDLE;
    A    = a_r;
    D    = d_r;
`ifdef CT_F_SPSRAM_CTRL_INIT_EN
    if (init_active_s) begin
      CEN  = 1'b0;
      GWEN = 1'b0;
      WEN  = WEN_WR;
      A    = init_cnt_r;
      D    = {DATA_WIDTH{1'b0}};
    end else
`endif
    if (wr_hs_s) begin
      CEN  = 1'b0;
      GWEN = 1'b0;
      WEN  = WEN_WR;
      A    = bus.req_addr;
      D    = bus.req_wdata;
    end else if (rd_hs_s) begin
      CEN  = 1'b0;
      A    = bus.req_addr;
    end else begin
      CEN  = 1'b1;
    end
  end

  // Last-driven A/D for hold, plus the one-cycle read-in-flight marker.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_r           <= {ADDR_WIDTH{1'b0}};
      d_r           <= {DATA_WIDTH{1'b0}};
      rd_inflight_r <= 1'b0;
    end else begin
      a_r           <= A;
      d_r           <= D;
      rd_inflight_r <= rd_hs_s;
    end
  end

  ct_f_spsram_ctrl_rspbuf #(
    .DEPTH (RSP_DEPTH),
    .DW    (DATA_WIDTH)
  ) u_rspbuf (
    .CLK       (CLK),
    .RST       (RST),
    .push      (rd_inflight_r),
    .push_data (Q),
    .pop       (buf_pop_s),
    .head_data (bus.rsp_data),
    .count     (buf_count_s),
    .empty     (buf_empty_s)
  );

endmodule

// File: tb/tb_ct_f_spsram_2048x128_ctrl.sv
// Randomized bench for ct_f_spsram_2048x128_ctrl with an SRAM model and a transaction-level reference.
module tb_ct_f_spsram_2048x128_ctrl;
  import ct_f_spsram_ctrl_pkg::*;

`ifdef CT_F_SPSRAM_CTRL_INIT_EN
  localparam int RUN_K = 2048;
`else
  localparam int RUN_K = 1;
`endif
  localparam int DEPTH = 2;

  logic         CLK;
  logic         RST;
  logic [10:0]  A;
  logic         CEN;
  logic         GWEN;
  logic [127:0] D;
  logic [127:0] WEN;
  logic [127:0] Q;

  ct_f_spsram_2048x128_ctrl_if #(.ADDR_WIDTH(11), .DATA_WIDTH(128)) bus ();

  ct_f_spsram_2048x128_ctrl dut (
    .CLK  (CLK),
    .RST  (RST),
    .bus  (bus),
    .A    (A),
    .CEN  (CEN),
    .GWEN (GWEN),
    .D    (D),
    .WEN  (WEN),
    .Q    (Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // SRAM behaviour: write masked by active-low WEN, read data appears after the edge.
  logic [127:0] sram [2048];
  always @(posedge CLK) begin
    if (CEN === 1'b0) begin
      if (GWEN === 1'b0) begin
        sram[A] <= (D & ~WEN) | (sram[A] & WEN);
      end else begin
        Q <= sram[A];
      end
    end
  end

  // Reference: memory contents by address and an ordered list of owed responses.
  typedef struct {
    logic [127:0] data;
    int           acc;
  } rsp_t;

  logic [127:0] ref_mem [2048];
  rsp_t         sbq [$];
  int           cyc = 0;
  int           k = 0;
  bit           armed = 1'b0;
  logic [10:0]  last_a = '0;
  logic [127:0] last_d = '0;
  logic         run_m, rdy_m, hs_m, vld_m;

  always @(negedge CLK) begin
    cyc++;
    if (armed) begin
      run_m = (k >= RUN_K);
      rdy_m = !RST && run_m && (sbq.size() < DEPTH);
      hs_m  = rdy_m && bus.req_vld;
      vld_m = (sbq.size() != 0) && ((cyc - sbq[0].acc) >= 2);
      chk("req_rdy", bus.req_rdy, rdy_m);
      chk("init_done", bus.init_done, run_m);
      chk("rsp_vld", bus.rsp_vld, vld_m);
      if (vld_m) chk("rsp_data", bus.rsp_data, sbq[0].data);
`ifdef CT_F_SPSRAM_CTRL_INIT_EN
      if (!RST && k < RUN_K) begin
        chk("init_cen", CEN, 1'b0);
        chk("init_gwen", GWEN, 1'b0);
        chk("init_wen", WEN, WEN_ALL0);
        chk("init_a", A, 11'(k));
        chk("init_d", D, 128'h0);
      end else
`endif
      if (hs_m) begin
        chk("req_cen", CEN, 1'b0);
        chk("req_gwen", GWEN, !bus.req_wr);
        chk("req_wen", WEN, bus.req_wr ? WEN_ALL0 : WEN_ALL1);
        chk("req_a", A, bus.req_addr);
        if (bus.req_wr) chk("req_d", D, bus.req_wdata);
      end else begin
        chk("idle_cen", CEN, 1'b1);
        chk("idle_gwen", GWEN, 1'b1);
        chk("idle_wen", WEN, WEN_ALL1);
        chk("idle_a", A, last_a);
        chk("idle_d", D, last_d);
      end
    end
    if (RST) begin
      k = 0;
      sbq.delete();
      last_a = '0;
      last_d = '0;
      armed  = 1'b1;
`ifdef CT_F_SPSRAM_CTRL_INIT_EN
      for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
`endif
    end else if (armed) begin
`ifdef CT_F_SPSRAM_CTRL_INIT_EN
      if (k < RUN_K) begin
        last_a = 11'(k);
        last_d = '0;
      end
`endif
      if (hs_m) begin
        last_a = bus.req_addr;
        if (bus.req_wr) begin
          ref_mem[bus.req_addr] = bus.req_wdata;
          last_d = bus.req_wdata;
        end else begin
          sbq.push_back('{ref_mem[bus.req_addr], cyc});
        end
      end
      if (vld_m && bus.rsp_rdy) void'(sbq.pop_front());
      if (k < RUN_K) k++;
    end
  end

  bit rand_rdy = 1'b0;

  task automatic step();
    @(posedge CLK);
    #1;
    if (rand_rdy) bus.rsp_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic do_req(input logic wr, input logic [10:0] addr, input logic [127:0] data,
                        output int waited);
    bus.req_vld   = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    waited = 0;
    while (1) begin
      @(negedge CLK);
      if (bus.req_rdy === 1'b1) break;
      waited++;
      if (waited > 200) begin
        fail_now("req_accept_timeout");
        break;
      end
      step();
    end
    step();
    bus.req_vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rand_rdy = 1'b0;
    bus.rsp_rdy = 1'b1;
    while (sbq.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (sbq.size() != 0) fail_now("drain_timeout");
  endtask

  task automatic read_check(input logic [10:0] addr, input logic [127:0] exp, input string nm);
    int w;
    bus.rsp_rdy = 1'b1;
    do_req(1'b0, addr, 128'h0, w);
    @(negedge CLK);
    chk({nm, "_lat1_vld"}, bus.rsp_vld, 1'b0);
    @(negedge CLK);
    chk({nm, "_lat2_vld"}, bus.rsp_vld, 1'b1);
    chk({nm, "_data"}, bus.rsp_data, exp);
    step();
  endtask

  localparam logic [127:0] DATA_123 = 128'hDEADBEEF_01234567_89ABCDEF_00000001;

  initial begin
    int w;
    int stalls;
    logic [10:0]  ra;
    logic [127:0] rd;
    for (int i = 0; i < 2048; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end
    Q             = '0;
    RST           = 1'b1;
    bus.req_vld   = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_rdy   = 1'b0;

    // Reset values while RST is held.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_cen", CEN, 1'b1);
    chk("rst_wen", WEN, WEN_ALL1);
    chk("rst_a", A, 11'h000);
    chk("rst_d", D, 128'h0);
    chk("rst_req_rdy", bus.req_rdy, 1'b0);
    chk("rst_rsp_vld", bus.rsp_vld, 1'b0);
    chk("rst_init_done", bus.init_done, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

`ifdef CT_F_SPSRAM_CTRL_INIT_EN
    for (int i = 0; i < 2048; i++) begin
      @(negedge CLK);
      chk("zf_a", A, 11'(i));
    end
    @(negedge CLK);
    chk("zf_done", bus.init_done, 1'b1);
    chk("zf_rdy", bus.req_rdy, 1'b1);
    step();
    read_check(11'h7FF, 128'h0, "zf_rd7ff");
`else
    @(negedge CLK);
    chk("rel_init_done0", bus.init_done, 1'b0);
    chk("rel_cen0", CEN, 1'b1);
    @(negedge CLK);
    chk("rel_init_done1", bus.init_done, 1'b1);
    chk("rel_rdy1", bus.req_rdy, 1'b1);
    step();
`endif

    // Write then read the same address on the next cycle.
    bus.rsp_rdy   = 1'b1;
    bus.req_vld   = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = 11'h123;
    bus.req_wdata = DATA_123;
    @(negedge CLK);
    chk("wr_wen", WEN, 128'h0);
    step();
    bus.req_wr = 1'b0;
    @(negedge CLK);
    chk("rd_wen", WEN, WEN_ALL1);
    chk("rd_a", A, 11'h123);
    step();
    bus.req_vld = 1'b0;
    @(negedge CLK);
    chk("rw_lat1", bus.rsp_vld, 1'b0);
    @(negedge CLK);
    chk("rw_lat2", bus.rsp_vld, 1'b1);
    chk("rw_data", bus.rsp_data, DATA_123);
    step();

    // Backpressure with a full response buffer.
    for (int i = 0; i < 3; i++) do_req(1'b1, 11'(16 + i), {96'h0, 32'hA5A50000 + i}, w);
    bus.rsp_rdy  = 1'b0;
    bus.req_vld  = 1'b1;
    bus.req_wr   = 1'b0;
    bus.req_addr = 11'h010;
    @(negedge CLK);
    chk("bp_rdy0", bus.req_rdy, 1'b1);
    step();
    bus.req_addr = 11'h011;
    @(negedge CLK);
    chk("bp_rdy1", bus.req_rdy, 1'b1);
    step();
    bus.req_addr = 11'h012;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("bp_stall", bus.req_rdy, 1'b0);
      if (i > 0) chk("bp_hold", bus.rsp_data, 128'h00000000_00000000_00000000_A5A50000);
      step();
    end
    bus.rsp_rdy = 1'b1;
    w = 0;
    while (1) begin
      @(negedge CLK);
      if (bus.req_rdy === 1'b1) break;
      w++;
      if (w > 20) begin
        fail_now("bp_resume_timeout");
        break;
      end
      step();
    end
    step();
    bus.req_vld = 1'b0;
    drain();

    // Streaming alternating write/read pairs.
    stalls = 0;
    for (int i = 0; i < 64; i++) begin
      ra = 11'($urandom_range(0, 2047));
      rd = {$urandom(), $urandom(), $urandom(), $urandom()};
      do_req(1'b1, ra, rd, w);
      stalls += w;
      do_req(1'b0, ra, 128'h0, w);
      stalls += w;
    end
    chk("stream_stalls", stalls, 0);
    drain();

    // Random traffic with random response backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        step();
      end else begin
        do_req(1'($urandom_range(0, 1)), 11'($urandom_range(0, 31)),
               {$urandom(), $urandom(), $urandom(), $urandom()}, w);
      end
    end
    drain();

    // Reset with one response buffered and one read in flight.
    bus.rsp_rdy  = 1'b0;
    bus.req_vld  = 1'b1;
    bus.req_wr   = 1'b0;
    bus.req_addr = 11'h010;
    @(negedge CLK);
    step();
    bus.req_addr = 11'h011;
    @(negedge CLK);
    step();
    bus.req_addr = 11'h012;
    RST = 1'b1;
    @(negedge CLK);
    chk("mr_pre_vld", bus.rsp_vld, 1'b1);
    step();
    @(negedge CLK);
    chk("mr_rsp_vld", bus.rsp_vld, 1'b0);
    chk("mr_cen", CEN, 1'b1);
    chk("mr_a", A, 11'h000);
    step();
    RST = 1'b0;
    bus.req_vld = 1'b0;
    bus.rsp_rdy = 1'b1;
    w = 0;
    while (bus.init_done !== 1'b1 && w < 3000) begin
      step();
      w++;
    end
    if (bus.init_done !== 1'b1) fail_now("mr_init_timeout");
    do_req(1'b1, 11'h055, 128'h5555_0000_0000_0000_0000_0000_0000_AAAA, w);
    read_check(11'h055, 128'h5555_0000_0000_0000_0000_0000_0000_AAAA, "mr_recover");
    drain();
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
